// File: rtl/axi_spi_pkg.sv
// Shared constants and types for the SPI master register bank.
package axi_spi_pkg;

   localparam logic [4:0] OFF_CTRL   = 5'h00;
   localparam logic [4:0] OFF_TIMING = 5'h04;
   localparam logic [4:0] OFF_TXDATA = 5'h08;
   localparam logic [4:0] OFF_RXDATA = 5'h0C;
   localparam logic [4:0] OFF_STATUS = 5'h10;
   localparam logic [4:0] OFF_CMD    = 5'h14;

   // Only word address bits [4:2] are decoded.
   localparam logic [2:0] IDX_CTRL   = OFF_CTRL[4:2];
   localparam logic [2:0] IDX_TIMING = OFF_TIMING[4:2];
   localparam logic [2:0] IDX_TXDATA = OFF_TXDATA[4:2];
   localparam logic [2:0] IDX_RXDATA = OFF_RXDATA[4:2];
   localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
   localparam logic [2:0] IDX_CMD    = OFF_CMD[4:2];

   localparam int CTRL_MODE_LSB  = 0;
   localparam int CTRL_SPEED_LSB = 2;
   localparam int CTRL_WLEN_LSB  = 4;
   localparam int CTRL_FLD_W     = 2;
   localparam int TIM_IFG_LSB    = 0;
   localparam int TIM_CS_SCK_LSB = 8;
   localparam int TIM_SCK_CS_LSB = 16;
   localparam int TIM_FLD_W      = 8;
   localparam logic [31:0] CTRL_MASK   = 32'h0000_003F;
   localparam logic [31:0] TIMING_MASK = 32'h00FF_FFFF;

   localparam int STAT_BUSY = 0;
   localparam int STAT_RXV  = 1;
   localparam int STAT_ACT  = 2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   localparam int RETRY_WAIT = 2;

   typedef enum logic [1:0] {SEQ_IDLE, SEQ_PULSE, SEQ_WAIT, SEQ_BUSY} seq_state_e;

   typedef struct packed {
      logic [2:0]  idx;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_req_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] strb, input logic [31:0] mask);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r & mask;
   endfunction

endpackage

// File: rtl/spi_start_seq.sv
// Start-pulse sequencer: pulses start_o, retries until the master goes busy,
// then captures the received frame when busy drops.
module spi_start_seq
   import axi_spi_pkg::*;
(
   input  logic        GCLK,
   input  logic        RST,
   input  logic        start_req,
   input  logic        rx_clr,
   input  logic        busy_i,
   input  logic [31:0] miso_data_i,
   output logic        start_o,
   output logic        seq_active,
   output logic [31:0] rx_data,
   output logic        rx_valid
);

   seq_state_e state;
   logic [1:0] wait_cnt;
   logic       capture;

   // BUSY is only entered with busy_i high, so a low busy_i here is the falling edge.
   assign capture    = (state == SEQ_BUSY) && !busy_i;
   assign seq_active = (state != SEQ_IDLE);

   always_ff @(posedge GCLK or negedge RST) begin
      if (!RST) begin
         state    <= SEQ_IDLE;
         start_o  <= 1'b0;
         wait_cnt <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         start_o <= 1'b0;
         case (state)
            SEQ_IDLE:
               if (start_req) begin
                  state   <= SEQ_PULSE;
                  start_o <= 1'b1;
               end
            SEQ_PULSE: begin
               state    <= SEQ_WAIT;
               wait_cnt <= '0;
            end
            SEQ_WAIT:
               if (busy_i) state <= SEQ_BUSY;
               else if (wait_cnt == 2'(RETRY_WAIT - 1)) begin
                  state   <= SEQ_PULSE;
                  start_o <= 1'b1;
               end else wait_cnt <= wait_cnt + 2'd1;
            SEQ_BUSY:
               if (!busy_i) state <= SEQ_IDLE;
            default: state <= SEQ_IDLE;
         endcase
         if (capture) begin
            rx_data  <= miso_data_i;
            rx_valid <= 1'b1;
         end else if (rx_clr) rx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_spi_regs.sv
// AXI4-Lite register bank feeding the SPI master config, TX data and start pulse.
module axi_spi_regs
   import axi_spi_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              GCLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] S_AXI_AWADDR,
   input  logic              S_AXI_AWVALID,
   output logic              S_AXI_AWREADY,
   input  logic [31:0]       S_AXI_WDATA,
   input  logic [3:0]        S_AXI_WSTRB,
   input  logic              S_AXI_WVALID,
   output logic              S_AXI_WREADY,
   output logic [1:0]        S_AXI_BRESP,
   output logic              S_AXI_BVALID,
   input  logic              S_AXI_BREADY,
   input  logic [ADDR_W-1:0] S_AXI_ARADDR,
   input  logic              S_AXI_ARVALID,
   output logic              S_AXI_ARREADY,
   output logic [31:0]       S_AXI_RDATA,
   output logic [1:0]        S_AXI_RRESP,
   output logic              S_AXI_RVALID,
   input  logic              S_AXI_RREADY,
   output logic              start_o,
   input  logic              busy_i,
   output logic [1:0]        spi_mode_o,
   output logic [1:0]        sck_speed_o,
   output logic [1:0]        word_len_o,
   output logic [7:0]        t_IFG_o,
   output logic [7:0]        t_CS_SCK_o,
   output logic [7:0]        t_SCK_CS_o,
   output logic [31:0]       mosi_data_o,
   input  logic [31:0]       miso_data_i
);

   logic        rdy_en, aw_held, w_held, aw_hs, w_hs, ar_hs, commit, wr_ok, cmd_req, rx_clr;
   logic [2:0]  aw_idx_q, ar_idx;
   logic [31:0] w_data_q, ctrl_q, tim_q, tx_q, rd_data, rx_data;
   logic [3:0]  w_strb_q;
   logic [1:0]  wr_resp, rd_resp;
   logic        seq_active, rx_valid, unused_addr;
   wr_req_t     wr;

   assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

   // Readies stay low through reset and rise the first cycle after release.
   assign S_AXI_AWREADY = rdy_en & ~aw_held;
   assign S_AXI_WREADY  = rdy_en & ~w_held;
   assign S_AXI_ARREADY = rdy_en & ~S_AXI_RVALID;

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // A handshake this cycle counts as held, so AW+W together commit at once.
   always_comb begin
      wr.idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[4:2];
      wr.data = w_held ? w_data_q : S_AXI_WDATA;
      wr.strb = w_held ? w_strb_q : S_AXI_WSTRB;
   end
   assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~S_AXI_BVALID;

   always_comb begin
      wr_resp = RESP_OKAY;
      case (wr.idx)
         IDX_CTRL, IDX_TIMING, IDX_TXDATA, IDX_CMD: if (seq_active) wr_resp = RESP_SLVERR;
         IDX_RXDATA, IDX_STATUS:                    wr_resp = RESP_OKAY;
         default:                                   wr_resp = RESP_DECERR;
      endcase
   end
   assign wr_ok   = commit & (wr_resp == RESP_OKAY);
   assign cmd_req = wr_ok & (wr.idx == IDX_CMD) & wr.strb[0] & wr.data[0];

   always_ff @(posedge GCLK or negedge RST) begin
      if (!RST) begin
         rdy_en       <= 1'b0;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx_q     <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         ctrl_q       <= '0;
         tim_q        <= '0;
         tx_q         <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp;
         end else begin
            if (aw_hs) begin
               aw_held  <= 1'b1;
               aw_idx_q <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
               w_held   <= 1'b1;
               w_data_q <= S_AXI_WDATA;
               w_strb_q <= S_AXI_WSTRB;
            end
            if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         end
         if (wr_ok)
            case (wr.idx)
               IDX_CTRL:   ctrl_q <= strb_merge(ctrl_q, wr.data, wr.strb, CTRL_MASK);
               IDX_TIMING: tim_q  <= strb_merge(tim_q, wr.data, wr.strb, TIMING_MASK);
               IDX_TXDATA: tx_q   <= strb_merge(tx_q, wr.data, wr.strb, '1);
               default: ;
            endcase
      end
   end

   assign ar_idx = S_AXI_ARADDR[4:2];
   assign rx_clr = ar_hs & (ar_idx == IDX_RXDATA);

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (ar_idx)
         IDX_CTRL:   rd_data = ctrl_q;
         IDX_TIMING: rd_data = tim_q;
         IDX_TXDATA: rd_data = tx_q;
         IDX_RXDATA: rd_data = rx_data;
         IDX_STATUS: begin
            rd_data[STAT_BUSY] = busy_i;
            rd_data[STAT_RXV]  = rx_valid;
            rd_data[STAT_ACT]  = seq_active;
         end
         IDX_CMD:    rd_data = '0;
         default:    rd_resp = RESP_DECERR;
      endcase
   end

   always_ff @(posedge GCLK or negedge RST) begin
      if (!RST) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_data;
         S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
   end

   spi_start_seq u_seq (
      .GCLK        (GCLK),
      .RST         (RST),
      .start_req   (cmd_req),
      .rx_clr      (rx_clr),
      .busy_i      (busy_i),
      .miso_data_i (miso_data_i),
      .start_o     (start_o),
      .seq_active  (seq_active),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid)
   );

   assign spi_mode_o  = ctrl_q[CTRL_MODE_LSB  +: CTRL_FLD_W];
   assign sck_speed_o = ctrl_q[CTRL_SPEED_LSB +: CTRL_FLD_W];
   assign word_len_o  = ctrl_q[CTRL_WLEN_LSB  +: CTRL_FLD_W];
   assign t_IFG_o     = tim_q[TIM_IFG_LSB    +: TIM_FLD_W];
   assign t_CS_SCK_o  = tim_q[TIM_CS_SCK_LSB +: TIM_FLD_W];
   assign t_SCK_CS_o  = tim_q[TIM_SCK_CS_LSB +: TIM_FLD_W];
   assign mosi_data_o = tx_q;

endmodule

// File: tb/tb_axi_spi_regs.sv
// Randomized bench for axi_spi_regs against a register-map level reference model.
module tb_axi_spi_regs;

   logic        GCLK = 1'b0, RST = 1'b0;
   logic [4:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
   logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 1, S_AXI_ARVALID = 0, S_AXI_RREADY = 1;
   logic [31:0] S_AXI_WDATA = '0, miso_data_i = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        busy_i = 0;
   logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, start_o;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP, spi_mode_o, sck_speed_o, word_len_o;
   logic [31:0] S_AXI_RDATA, mosi_data_o;
   logic [7:0]  t_IFG_o, t_CS_SCK_o, t_SCK_CS_o;

   axi_spi_regs #(.ADDR_W(5)) dut (
      .GCLK(GCLK), .RST(RST),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .start_o(start_o), .busy_i(busy_i),
      .spi_mode_o(spi_mode_o), .sck_speed_o(sck_speed_o), .word_len_o(word_len_o),
      .t_IFG_o(t_IFG_o), .t_CS_SCK_o(t_CS_SCK_o), .t_SCK_CS_o(t_SCK_CS_o),
      .mosi_data_o(mosi_data_o), .miso_data_i(miso_data_i)
   );

   always #5 GCLK = ~GCLK;

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: register contents by map, plus sequencer-level flags.
   logic [31:0] m_ctrl = '0, m_tim = '0, m_tx = '0, m_rx = '0;
   bit          m_rxv = 0, m_act = 0;

   function automatic logic [31:0] bmask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] r);
      logic [31:0] m;
      m = bmask(s);
      r = 2'd0;
      case (a[4:2])
         3'd0: if (m_act) r = 2'd2; else m_ctrl = ((m_ctrl & ~m) | (d & m)) & 32'h3F;
         3'd1: if (m_act) r = 2'd2; else m_tim = ((m_tim & ~m) | (d & m)) & 32'hFF_FFFF;
         3'd2: if (m_act) r = 2'd2; else m_tx = (m_tx & ~m) | (d & m);
         3'd5: if (m_act) r = 2'd2;
         3'd3, 3'd4: r = 2'd0;
         default: r = 2'd3;
      endcase
   endtask

   task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      r = 2'd0;
      d = '0;
      case (a[4:2])
         3'd0: d = m_ctrl;
         3'd1: d = m_tim;
         3'd2: d = m_tx;
         3'd3: begin d = m_rx; m_rxv = 0; end
         3'd4: d = {29'd0, m_act, m_rxv, busy_i};
         3'd5: d = '0;
         default: r = 2'd3;
      endcase
   endtask

   task automatic check_cfg();
      chk("spi_mode", spi_mode_o, m_ctrl[1:0]);
      chk("sck_speed", sck_speed_o, m_ctrl[3:2]);
      chk("word_len", word_len_o, m_ctrl[5:4]);
      chk("t_IFG", t_IFG_o, m_tim[7:0]);
      chk("t_CS_SCK", t_CS_SCK_o, m_tim[15:8]);
      chk("t_SCK_CS", t_SCK_CS_o, m_tim[23:16]);
      chk("mosi", mosi_data_o, m_tx);
   endtask

   // start_o monitor: pulse count, pulse cycle stamps, one-cycle width.
   int cyc = 0, npulse = 0;
   int pulse_cyc[$];
   bit prev_start = 0;
   always @(negedge GCLK) begin
      cyc++;
      if (start_o) begin
         chk("start_width", prev_start, 0);
         npulse++;
         pulse_cyc.push_back(cyc);
      end
      prev_start = start_o;
   end

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r);
      int n = 0;
      bit aw_go, w_go;
      @(negedge GCLK);
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
         aw_go = S_AXI_AWREADY;
         w_go  = S_AXI_WREADY;
         @(negedge GCLK);
         n++;
         if (aw_go) S_AXI_AWVALID = 0;
         if (w_go)  S_AXI_WVALID = 0;
      end
      while (!S_AXI_BVALID && n < 20) begin @(negedge GCLK); n++; end
      chk("b_valid", S_AXI_BVALID, 1);
      chk("b_latency", n, 1);
      r = S_AXI_BRESP;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
   endtask

   task automatic axi_read(input logic [4:0] a, input bit drop_busy, output logic [31:0] d,
                           output logic [1:0] r);
      int n = 0;
      @(negedge GCLK);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
      if (drop_busy) busy_i = 0;
      while (!S_AXI_ARREADY && n < 20) begin @(negedge GCLK); n++; end
      chk("ar_ready", S_AXI_ARREADY, 1);
      @(negedge GCLK);
      S_AXI_ARVALID = 0;
      chk("r_valid", S_AXI_RVALID, 1);
      d = S_AXI_RDATA;
      r = S_AXI_RRESP;
   endtask

   task automatic wr_check(input string tag, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic [1:0] r, er;
      axi_write(a, d, s, r);
      model_write(a, d, s, er);
      chk(tag, r, er);
      check_cfg();
   endtask

   task automatic rd_check(input string tag, input logic [4:0] a);
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      axi_read(a, 0, d, r);
      model_read(a, ed, er);
      chk({tag, "_data"}, d, ed);
      chk({tag, "_resp"}, r, er);
   endtask

   // CMD start, busy raised n cycles after the first pulse; pulses every 3 cycles until then.
   task automatic run_cmd(input int n);
      logic [1:0] r;
      int p0;
      p0 = npulse;
      pulse_cyc.delete();
      axi_write(5'h14, 32'h1, 4'h1, r);
      chk("cmd_resp", r, 0);
      m_act = 1;
      repeat (n) @(negedge GCLK);
      busy_i = 1;
      repeat (8) @(negedge GCLK);
      chk("pulse_cnt", npulse - p0, n / 3 + 1);
      for (int i = 1; i < pulse_cyc.size(); i++)
         chk("pulse_period", pulse_cyc[i] - pulse_cyc[i-1], 3);
   endtask

   task automatic end_busy(input logic [31:0] miso);
      @(negedge GCLK);
      miso_data_i = miso;
      busy_i = 0;
      @(negedge GCLK);
      m_rx = miso; m_rxv = 1; m_act = 0;
   endtask

   logic [4:0]  addrs [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
   logic [4:0]  a;
   logic [31:0] d, v;
   logic [1:0]  r;
   int          p0;

   initial begin
      repeat (2) @(negedge GCLK);
      chk("rst_awready", S_AXI_AWREADY, 0);
      chk("rst_wready", S_AXI_WREADY, 0);
      chk("rst_arready", S_AXI_ARREADY, 0);
      chk("rst_bvalid", {S_AXI_BVALID, S_AXI_BRESP}, 0);
      chk("rst_rvalid", {S_AXI_RVALID, S_AXI_RRESP}, 0);
      chk("rst_rdata", S_AXI_RDATA, 0);
      chk("rst_start", start_o, 0);
      check_cfg();
      RST = 1;
      #1 chk("rel_awready0", S_AXI_AWREADY, 0);
      @(negedge GCLK);
      chk("rel_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

      wr_check("ctrl_resp", 5'h00, 32'h0000_0036, 4'hF);
      wr_check("timing_resp", 5'h04, 32'h0003_0204, 4'hF);

      // W one cycle ahead of AW, low half strobes only.
      @(negedge GCLK);
      S_AXI_WDATA = 32'hA5A5_5A5A; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1;
      @(negedge GCLK);
      S_AXI_WVALID = 0; S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1;
      chk("wfirst_nob", S_AXI_BVALID, 0);
      @(negedge GCLK);
      S_AXI_AWVALID = 0;
      chk("wfirst_bvalid", S_AXI_BVALID, 1);
      model_write(5'h08, 32'hA5A5_5A5A, 4'h3, r);
      chk("wfirst_bresp", S_AXI_BRESP, r);
      check_cfg();

      for (int i = 0; i < 30; i++) begin
         a = addrs[$urandom_range(0, 7)] | 5'($urandom_range(0, 3));
         d = $urandom;
         if (a[4:2] == 3'd5) d[0] = 1'b0;
         wr_check("rnd_wresp", a, d, 4'($urandom_range(0, 15)));
         busy_i = $urandom_range(0, 1);
         rd_check("rnd_rd", addrs[$urandom_range(0, 7)] | 5'($urandom_range(0, 3)));
      end
      busy_i = 0;

      // Single transfer, then a blocked write and status while busy.
      run_cmd(1);
      wr_check("busy_tx_resp", 5'h08, $urandom, 4'hF);
      wr_check("busy_ctrl_resp", 5'h00, $urandom, 4'hF);
      rd_check("busy_status", 5'h10);
      end_busy(32'h1234_5678);
      chk("after_pulses", pulse_cyc.size(), 1);
      rd_check("done_status", 5'h10);
      rd_check("done_rx", 5'h0C);
      rd_check("rxv_clr_status", 5'h10);

      // Master ignores starts for a while: retries every 3 cycles.
      run_cmd(10);
      p0 = npulse;
      repeat (20) @(negedge GCLK);
      chk("no_pulse_in_busy", npulse - p0, 0);
      end_busy($urandom);
      rd_check("retry_rx", 5'h0C);
      run_cmd($urandom_range(2, 12));

      // RXDATA read on the busy_i falling cycle: old data, capture wins rx_valid.
      v = $urandom;
      miso_data_i = v;
      axi_read(5'h0C, 1, d, r);
      chk("race_rx_old", d, m_rx);
      chk("race_rx_resp", r, 0);
      m_rx = v; m_rxv = 1; m_act = 0;
      rd_check("race_status", 5'h10);
      rd_check("race_rx_new", 5'h0C);

      rd_check("decerr_rd18", 5'h18);
      wr_check("decerr_wr1c", 5'h1C, $urandom, 4'hF);
      rd_check("cmd_rd", 5'h14);

      // Reset while the master is busy.
      run_cmd(1);
      @(negedge GCLK);
      RST = 0;
      #1;
      chk("rstb_start", start_o, 0);
      chk("rstb_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
      chk("rstb_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
      chk("rstb_rdata", S_AXI_RDATA, 0);
      m_ctrl = '0; m_tim = '0; m_tx = '0; m_rx = '0; m_rxv = 0; m_act = 0;
      check_cfg();
      busy_i = 0;
      p0 = npulse;
      @(negedge GCLK);
      RST = 1;
      rd_check("post_rst_status", 5'h10);
      rd_check("post_rst_rx", 5'h0C);
      chk("post_rst_pulses", npulse - p0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
      $fatal(1);
   end

endmodule

// File: doc/axi_spi_regs.md
# axi_spi_regs

AXI4-Lite slave register bank that sits directly upstream of the SPI master. It holds the master's configuration, timing and TX data, and issues the single-cycle start pulse. The pulse is retried until the master accepts it, and the received frame is captured when the transfer ends. All master-side ports connect one-to-one to the SPI master's control, config, status and data ports.

## Interface
- ADDR_W, 5: AXI address width; byte addressing, only bits [4:2] decoded.
- GCLK  in  1  global clock.
- RST  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_W/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_W/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- start_o  out  1  start pulse to the master.
- busy_i  in  1  master busy flag.
- spi_mode_o, sck_speed_o, word_len_o  out  2 each  from CTRL.
- t_IFG_o, t_CS_SCK_o, t_SCK_CS_o  out  8 each  from TIMING.
- mosi_data_o  out  32  from TXDATA.
- miso_data_i  in  32  received frame.

## Operation
- Register map; all registers reset to 0:
  - 0x00 CTRL (RW): [1:0] spi_mode, [3:2] sck_speed, [5:4] word_len.
  - 0x04 TIMING (RW): [7:0] t_IFG, [15:8] t_CS_SCK, [23:16] t_SCK_CS.
  - 0x08 TXDATA (RW).
  - 0x0C RXDATA (RO).
  - 0x10 STATUS (RO): [0] busy_i, [1] rx_valid, [2] seq_active (sequencer state not IDLE).
  - 0x14 CMD (WO): write of bit0=1 requests a start; reads return 0.
- Write strobes are byte-wise. Unused bits read 0.
- Write acceptance:
  - AW and W are accepted independently into one-entry holding registers. AWREADY = !aw_held; WREADY = !w_held.
  - When both are held and BVALID=0, the write commits and BVALID is asserted with BRESP. BVALID holds until BREADY.
- Write responses:
  - Unmapped address → DECERR (3), no effect.
  - Write to CTRL/TIMING/TXDATA/CMD while seq_active=1 → SLVERR (2), dropped. Config therefore never changes mid-frame.
  - Write to RXDATA/STATUS → OKAY, ignored.
- Read: ARREADY = !RVALID. RDATA/RRESP are registered at AR handshake; unmapped address → DECERR, RDATA=0. AR handshake on RXDATA clears rx_valid.
- Start sequencer, states IDLE, PULSE, WAIT, BUSY:
  - IDLE → PULSE on accepted CMD bit0 write.
  - PULSE: start_o=1 for exactly 1 cycle → WAIT.
  - WAIT: start_o=0; counter up to 2 cycles. If busy_i=1 → BUSY. Counter expiry with busy_i=0 → PULSE (retry; the master drops starts during its interframe gap). There is no retry limit.
  - BUSY → IDLE on the busy_i falling edge. Same cycle: RXDATA ← miso_data_i, rx_valid ← 1.
- Simultaneous capture and RXDATA read: the read returns the old data, and rx_valid ends at 1 (capture wins).

## Timing
- Outputs under reset: all READY/VALID 0, BRESP/RRESP 0, RDATA 0, start_o 0, config outputs 0, sequencer IDLE. AWREADY/WREADY/ARREADY rise the first cycle after release.
- Write latency: AW+W in the same cycle → BVALID next cycle; config outputs update that same cycle.
- Read latency: 1 cycle from AR handshake to RVALID.
- CMD write commit → start_o high the next cycle.
- Retry period: 3 cycles (1 high, 2 low), which gives the master a fresh rising edge each time.
- Reset asserted mid-transfer: sequencer returns to IDLE and start_o=0 immediately. The master is reset by the same reset.

## Structure
- Package axi_spi_pkg holds:
  - register offsets;
  - field LSB/width constants;
  - AXI response codes (OKAY=0, SLVERR=2, DECERR=3);
  - sequencer state enum.
- Sub-module spi_start_seq contains the sequencer FSM, retry counter and RX capture (inputs busy_i, miso_data_i, start request; outputs start_o, seq_active, rx data/valid). The top level is the AXI channels and the register file.

## Test plan
- Write CTRL=0x0000_0036, TIMING=0x0003_0204 → BRESP=0; spi_mode_o=2, sck_speed_o=1, word_len_o=3, t_IFG_o=4, t_CS_SCK_o=2, t_SCK_CS_o=3.
- W one cycle before AW to TXDATA=0xA5A5_5A5A with WSTRB=0x3 → only the low half updates; BVALID one cycle after AW.
- CMD=1, busy_i rises 1 cycle after the pulse, falls 40 cycles later, miso_data_i=0x1234_5678 → exactly one start_o pulse; RXDATA=0x1234_5678; STATUS=0x2.
- CMD=1 with busy_i held 0 for 10 cycles, then 1 → start_o pulses every 3 cycles; no pulse after busy_i rises.
- Write TXDATA while seq_active → BRESP=2, TXDATA unchanged. Read 0x18 → RRESP=3, RDATA=0.
- RXDATA read in the busy_i falling cycle → returns old data; STATUS[1]=1 afterwards. Reset asserted in BUSY → all outputs at reset values.
